// File: rtl/trig_lut_arbiter.sv
// Round-robin arbiter sharing one synchronous sin/cos ROM between NUM_REQ motion requesters.
// Define TRIG_CACHE_EN to add a per-requester result cache that bypasses the ROM on repeat headings.
module trig_lut_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned ANGLE_W     = 6,
   parameter int unsigned ANGLE_COUNT = 45,
   parameter int unsigned TRIG_W      = 8,
   parameter int unsigned ROM_LAT     = 1
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*ANGLE_W-1:0] angle_in,
   output logic [NUM_REQ-1:0]         ack,
   output logic [TRIG_W-1:0]          sin_out,
   output logic [TRIG_W-1:0]          cos_out,
   output logic                       angle_err,
   output logic                       busy,
   output logic                       rom_en,
   output logic [ANGLE_W-1:0]         rom_addr,
   input  logic [TRIG_W-1:0]          rom_sin,
   input  logic [TRIG_W-1:0]          rom_cos
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]    gnt_q, gnt_d;
   logic                err_q, err_d;
   logic [2:0]          cnt_q, cnt_d;
   logic                rom_en_q, rom_en_d;
   logic [ANGLE_W-1:0]  rom_addr_q, rom_addr_d;
   logic [TRIG_W-1:0]   sin_q, sin_d;
   logic [TRIG_W-1:0]   cos_q, cos_d;

   logic                found;
   logic [IDX_W-1:0]    pick;
   logic [IDX_W-1:0]    cidx;
   int unsigned         cand;
   logic [ANGLE_W-1:0]  sel_angle;
   logic                in_range;
   logic                capture;

`ifdef TRIG_CACHE_EN
   logic [ANGLE_W-1:0]  angle_q, angle_d;
   logic                c_vld_q [NUM_REQ];
   logic [ANGLE_W-1:0]  c_ang_q [NUM_REQ];
   logic [TRIG_W-1:0]   c_sin_q [NUM_REQ];
   logic [TRIG_W-1:0]   c_cos_q [NUM_REQ];
   logic                hit;
`endif

   // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = 0;
      cidx  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = (32'(rr_ptr_q) + i) % NUM_REQ;
         cidx = IDX_W'(cand);
         if (!found && req[cidx]) begin
            found = 1'b1;
            pick  = cidx;
         end
      end
   end

   assign sel_angle = angle_in[32'(pick)*ANGLE_W +: ANGLE_W];
   assign in_range  = 32'(sel_angle) < ANGLE_COUNT;
   assign capture   = (state_q == READ) && (cnt_q == 3'd0);

`ifdef TRIG_CACHE_EN
   assign hit = in_range && c_vld_q[pick] && (c_ang_q[pick] == sel_angle);
`endif

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      gnt_d      = gnt_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      rom_en_d   = 1'b0;
      rom_addr_d = rom_addr_q;
      sin_d      = sin_q;
      cos_d      = cos_q;
`ifdef TRIG_CACHE_EN
      angle_d    = angle_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d = pick;
               err_d = !in_range;
`ifdef TRIG_CACHE_EN
               angle_d = sel_angle;
               if (hit) begin
                  sin_d   = c_sin_q[pick];
                  cos_d   = c_cos_q[pick];
                  state_d = RESP;
               end else begin
`else
               begin
`endif
                  rom_addr_d = in_range ? sel_angle : '0;
                  rom_en_d   = 1'b1;
                  cnt_d      = 3'(ROM_LAT);
                  state_d    = READ;
               end
            end
         end
         // cnt starts at ROM_LAT so the capture lands ROM_LAT+1 edges after the grant.
         READ: begin
            if (cnt_q == 3'd0) begin
               sin_d   = rom_sin;
               cos_d   = rom_cos;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP: begin
            rr_ptr_d = (32'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         gnt_q      <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         rom_en_q   <= 1'b0;
         rom_addr_q <= '0;
         sin_q      <= '0;
         cos_q      <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_q      <= gnt_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         rom_en_q   <= rom_en_d;
         rom_addr_q <= rom_addr_d;
         sin_q      <= sin_d;
         cos_q      <= cos_d;
      end
   end

`ifdef TRIG_CACHE_EN
   always_ff @(posedge Clk) begin
      if (Reset) begin
         angle_q <= '0;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            c_vld_q[i] <= 1'b0;
            c_ang_q[i] <= '0;
            c_sin_q[i] <= '0;
            c_cos_q[i] <= '0;
         end
      end else begin
         angle_q <= angle_d;
         if (capture && !err_q) begin
            c_vld_q[gnt_q] <= 1'b1;
            c_ang_q[gnt_q] <= angle_q;
            c_sin_q[gnt_q] <= rom_sin;
            c_cos_q[gnt_q] <= rom_cos;
         end
      end
   end
`endif

   assign ack       = (state_q == RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
   assign angle_err = (state_q == RESP) && err_q;
   assign busy      = (state_q != IDLE);
   assign rom_en    = rom_en_q;
   assign rom_addr  = rom_addr_q;
   assign sin_out   = sin_q;
   assign cos_out   = cos_q;

endmodule

// File: tb/tb_trig_lut_arbiter.sv
// Directed self-checking bench for trig_lut_arbiter with a 1-cycle behavioural trig ROM.
// Define TRIG_CACHE_EN to also exercise the result cache.
module tb_trig_lut_arbiter;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [3:0]  req;
   logic [23:0] angle_in;
   logic [3:0]  ack;
   logic [7:0]  sin_out, cos_out;
   logic        angle_err, busy, rom_en;
   logic [5:0]  rom_addr;
   logic [7:0]  rom_sin, rom_cos;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic [7:0]  exp_sin_of [4];

   trig_lut_arbiter #(
      .NUM_REQ(4), .ANGLE_W(6), .ANGLE_COUNT(45), .TRIG_W(8), .ROM_LAT(1)
   ) dut (
      .Clk(Clk), .Reset(Reset), .req(req), .angle_in(angle_in), .ack(ack),
      .sin_out(sin_out), .cos_out(cos_out), .angle_err(angle_err), .busy(busy),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_sin(rom_sin), .rom_cos(rom_cos)
   );

   always #5 Clk = ~Clk;

   // ROM contents: entry 11 is sin=7F cos=00, else sin=3a+1, cos=80|a.
   always @(posedge Clk) begin
      if (rom_en) begin
         rom_sin <= (rom_addr == 6'd11) ? 8'h7F : 8'(rom_addr * 3 + 1);
         rom_cos <= (rom_addr == 6'd11) ? 8'h00 : (8'h80 | {2'b00, rom_addr});
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One isolated request; lat = negedges from request to ack (3 for ROM path, 1 for cache hit).
   task automatic single(input int idx, input logic [5:0] ang, input int lat,
                         input logic [5:0] exp_addr, input logic [7:0] exp_sin,
                         input logic [7:0] exp_cos, input logic exp_err);
      req = '0;
      req[idx] = 1'b1;
      angle_in[idx*6 +: 6] = ang;
      for (int c = 1; c <= lat; c++) begin
         @(negedge Clk);
         if (c == 1) begin
            check("rom_en", 32'(rom_en), (lat == 1) ? 32'd0 : 32'd1);
            if (lat != 1) check("rom_addr", 32'(rom_addr), 32'(exp_addr));
         end
         if (c < lat) check("ack_early", 32'(ack), 32'd0);
      end
      check("ack", 32'(ack), 32'd1 << idx);
      check("sin_out", 32'(sin_out), 32'(exp_sin));
      check("cos_out", 32'(cos_out), 32'(exp_cos));
      check("angle_err", 32'(angle_err), 32'(exp_err));
      req = '0;
      @(negedge Clk);
   endtask

   // All bits of mask requested together; each dropped on its own ack.
   task automatic burst(input logic [3:0] mask, input int n, input int order [4]);
      logic got;
      req = mask;
      for (int k = 0; k < n; k++) begin
         got = 1'b0;
         for (int c = 0; c < 12 && !got; c++) begin
            @(negedge Clk);
            if (ack != 4'b0000) got = 1'b1;
         end
         check("burst_ack", 32'(ack), 32'd1 << order[k]);
         if (got) check("burst_sin", 32'(sin_out), 32'(exp_sin_of[order[k]]));
         req = req & ~ack;
      end
      req = '0;
      @(negedge Clk);
   endtask

   initial begin
      logic quiet;
      int ord [4];
      Reset = 1'b1;
      req = '0;
      angle_in = '0;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;

      for (int c = 0; c < 20; c++) begin
         @(negedge Clk);
         check("idle_quiet", {29'd0, ack == 4'b0, busy, rom_en}, {29'd0, 1'b1, 1'b0, 1'b0});
      end
      check("reset_sin", 32'(sin_out), 32'd0);
      check("reset_cos", 32'(cos_out), 32'd0);

      single(0, 6'd11, 3, 6'd11, 8'h7F, 8'h00, 1'b0);

      // Restart from rr_ptr=0 for the fairness bursts.
      Reset = 1'b1; @(negedge Clk); Reset = 1'b0; @(negedge Clk);
      angle_in = {6'd4, 6'd3, 6'd2, 6'd1};
      exp_sin_of = '{8'h04, 8'h07, 8'h0A, 8'h0D};
      ord = '{0, 1, 2, 3};
      burst(4'b1111, 4, ord);
      ord = '{2, 0, 0, 0};
      burst(4'b0100, 1, ord);
      ord = '{3, 0, 1, 2};
      burst(4'b1111, 4, ord);

      single(2, 6'd50, 3, 6'd0, 8'h01, 8'h80, 1'b1);

      // Reset during READ; rr_ptr was 3, so req 1001 must now serve 0 first.
      req = 4'b0010;
      angle_in[6 +: 6] = 6'd7;
      @(negedge Clk);
      check("abort_rom_en", 32'(rom_en), 32'd1);
      check("abort_busy", 32'(busy), 32'd1);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      req = '0;
      quiet = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge Clk);
         if (ack != 4'b0 || busy) quiet = 1'b0;
      end
      check("abort_no_ack", 32'(quiet), 32'd1);
      angle_in[0 +: 6]  = 6'd9;
      angle_in[18 +: 6] = 6'd20;
      exp_sin_of[0] = 8'h1C;
      exp_sin_of[3] = 8'h3D;
      ord = '{0, 3, 0, 0};
      burst(4'b1001, 2, ord);

`ifdef TRIG_CACHE_EN
      single(1, 6'd5, 3, 6'd5, 8'h10, 8'h85, 1'b0);
      single(1, 6'd5, 1, 6'd5, 8'h10, 8'h85, 1'b0);
      single(1, 6'd6, 3, 6'd6, 8'h13, 8'h86, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
